keypad_scanner: RTL

- Scanned 4x4 matrix keypad reader. It is the input-side counterpart of the multiplexed active-low display scan.
- Drives one keypad column low at a time and reads the active-low row lines. Debounces and encodes a single key press.
- Presents the key code to downstream control logic (display/CPU I/O register) over a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/scan_tick_gen.sv | 23 ++
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the FSM state encoding and helpers for decoding active-low lines.
package keypad_pkg;

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        WAIT_RELEASE
    } state_t;

    function automatic logic single_low(input logic [3:0] lines);
        return ($countones(~lines) == 1);
    endfunction

    // Index of the lowest-numbered line that is driven low.
    function automatic logic [1:0] low_index(input logic [3:0] lines);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (!lines[i-1]) idx = 2'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned     CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]   LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, debounce, key encode, valid/ready output.
// Define KEYPAD_REPEAT_EN to build the auto-repeat hold counter.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_TICKS   = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic                key_held
);

    localparam logic [4:0] DEB_LAST = 5'(DEBOUNCE_SCANS);

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta, row_sync;
    state_t              state, state_nx;
    logic [NUM_COLS-1:0] col_nx, col_adv;
    logic [1:0]          row_idx, row_idx_nx, col_idx;
    logic [3:0]          deb_cnt, deb_cnt_nx, rel_cnt, rel_cnt_nx;
    logic [4:0]          deb_inc, rel_inc;
    logic [KEY_W-1:0]    key_code_nx;
    logic                key_valid_nx, key_held_nx;
    logic                row_released, same_row;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned   HW        = $clog2(REPEAT_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_TICKS);
    logic [HW-1:0] hold_cnt, hold_cnt_nx, hold_inc;
    assign hold_inc = hold_cnt + 1'b1;
`endif

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    assign col_adv      = {col_n[NUM_COLS-2:0], col_n[NUM_COLS-1]};
    assign col_idx      = low_index(col_n);
    assign deb_inc      = {1'b0, deb_cnt} + 5'd1;
    assign rel_inc      = {1'b0, rel_cnt} + 5'd1;
    assign row_released = row_sync[row_idx];
    assign same_row     = single_low(row_sync) && (low_index(row_sync) == row_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_n     <= COL_RESET;
            row_idx   <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nx;
            col_n     <= col_nx;
            row_idx   <= row_idx_nx;
            deb_cnt   <= deb_cnt_nx;
            rel_cnt   <= rel_cnt_nx;
            key_code  <= key_code_nx;
            key_valid <= key_valid_nx;
            key_held  <= key_held_nx;
`ifdef KEYPAD_REPEAT_EN
            hold_cnt  <= hold_cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx     = state;
        col_nx       = col_n;
        row_idx_nx   = row_idx;
        deb_cnt_nx   = deb_cnt;
        rel_cnt_nx   = rel_cnt;
        key_code_nx  = key_code;
        key_valid_nx = key_valid;
        key_held_nx  = key_held;
`ifdef KEYPAD_REPEAT_EN
        hold_cnt_nx  = hold_cnt;
`endif
        case (state)
            SCAN: begin
                if (tick) begin
                    if (single_low(row_sync)) begin
                        row_idx_nx = low_index(row_sync);
                        deb_cnt_nx = '0;
                        state_nx   = DEBOUNCE;
                    end else begin
                        col_nx = col_adv;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (same_row) begin
                        deb_cnt_nx = deb_inc[3:0];
                        if (deb_inc == DEB_LAST) begin
                            key_code_nx  = {row_idx, col_idx};
                            key_valid_nx = 1'b1;
                            key_held_nx  = 1'b1;
                            rel_cnt_nx   = '0;
                            state_nx     = REPORT;
                        end
                    end else begin
                        col_nx   = col_adv;
                        state_nx = SCAN;
                    end
                end
            end
            REPORT: begin
                // Release is debounced here too so key_held can drop before the consumer responds.
                if (tick && key_held) begin
                    if (row_released) begin
                        rel_cnt_nx = rel_inc[3:0];
                        if (rel_inc == DEB_LAST) key_held_nx = 1'b0;
                    end else begin
                        rel_cnt_nx = '0;
                    end
                end
                if (key_valid && key_ready) begin
                    key_valid_nx = 1'b0;
`ifdef KEYPAD_REPEAT_EN
                    hold_cnt_nx  = '0;
`endif
                    if (!key_held_nx) begin
                        col_nx   = col_adv;
                        state_nx = SCAN;
                    end else begin
                        state_nx = WAIT_RELEASE;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (tick) begin
                    if (row_released) begin
`ifdef KEYPAD_REPEAT_EN
                        hold_cnt_nx = '0;
`endif
                        rel_cnt_nx = rel_inc[3:0];
                        if (rel_inc == DEB_LAST) begin
                            key_held_nx = 1'b0;
                            col_nx      = col_adv;
                            state_nx    = SCAN;
                        end
                    end else begin
                        rel_cnt_nx = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (hold_inc == HOLD_LAST) begin
                            key_valid_nx = 1'b1;
                            hold_cnt_nx  = '0;
                            state_nx     = REPORT;
                        end else begin
                            hold_cnt_nx = hold_inc;
                        end
`endif
                    end
                end
            end
            default: state_nx = SCAN;
        endcase
    end

endmodule
